alu_packet_ctrl: RTL

Packet-level controller that sequences the UART ALU datapath. It sits between the UART receiver and transmitter byte streams. It parses each incoming command packet (opcode + length header, little-endian 32-bit operands) and runs the selected operation: echo, add, multiply, or iterative divide. It returns the result bytes through the TX handshake, stalling RX whenever TX or the divider is busy.

---
 rtl/alu_packet_ctrl.sv | 297 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_packet_ctrl.sv
// alu_packet_ctrl: packet-level sequencer for the UART ALU datapath.
// Parses opcode/length headers, folds little-endian 32-bit operands into an
// accumulator (echo / add / multiply / divide) and returns results over TX.
// Optional feature macro: ALU_DIV_EN enables opcode 0xD1 (iterative divide).
module alu_packet_ctrl #(
   parameter int LEN_W = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data_i,
   input  logic       rx_valid_i,
   output logic       rx_ready_o,
   output logic [7:0] tx_data_o,
   output logic       tx_valid_o,
   input  logic       tx_ready_i,
   output logic       busy_o
);

   localparam logic [7:0] OP_ECHO = 8'hEC;
   localparam logic [7:0] OP_ADD  = 8'hAD;
   localparam logic [7:0] OP_MUL  = 8'hAC;
`ifdef ALU_DIV_EN
   localparam logic [7:0] OP_DIV  = 8'hD1;
`endif

   typedef enum logic [3:0] {
      S_HDR0,
      S_HDR1,
      S_HDR2,
      S_HDR3,
      S_PAYLOAD,
      S_DRAIN,
      S_ECHO_TX,
      S_SEND
`ifdef ALU_DIV_EN
      , S_DIV_RUN
`endif
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       op_q, op_d;
   logic [7:0]       len_lo_q, len_lo_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic [1:0]       bcnt_q, bcnt_d;
   logic [31:0]      word_q, word_d;
   logic [31:0]      acc_q, acc_d;
   logic [1:0]       sidx_q, sidx_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             tx_valid_q, tx_valid_d;
   logic             rx_ready_q;
   logic             busy_q;

`ifdef ALU_DIV_EN
   logic             first_q, first_d;
   logic [31:0]      dq_q, dq_d;
   logic [31:0]      dr_q, dr_d;
   logic [31:0]      dv_q, dv_d;
   logic [4:0]       dcnt_q, dcnt_d;
   logic             dlast_q, dlast_d;
   logic [32:0]      r_sh;
   logic             r_ge;
   logic [31:0]      dr_nx;
   logic [31:0]      q_nx;
   logic             is_div;
`endif

   logic        rx_fire, tx_fire;
   logic [31:0] word_nx;
   logic        word_done, last_byte;
   logic [15:0] hdr_len, pay_len;
   logic        is_echo, is_add, is_mul, is_arith;
   logic [31:0] acc_fold;

   assign rx_fire   = rx_valid_i & rx_ready_q;
   assign tx_fire   = tx_valid_q & tx_ready_i;
   assign word_nx   = {rx_data_i, word_q[31:8]};
   assign word_done = (bcnt_q == 2'd3);
   assign last_byte = (rem_q == LEN_W'(1));
   assign hdr_len   = {rx_data_i, len_lo_q};
   assign pay_len   = (hdr_len < 16'd4) ? 16'd0 : hdr_len - 16'd4;

   assign is_echo = (op_q == OP_ECHO);
   assign is_add  = (op_q == OP_ADD);
   assign is_mul  = (op_q == OP_MUL);
`ifdef ALU_DIV_EN
   assign is_div   = (op_q == OP_DIV);
   assign is_arith = is_add | is_mul | is_div;
`else
   assign is_arith = is_add | is_mul;
`endif

   assign rx_ready_o = rx_ready_q;
   assign tx_data_o  = tx_data_q;
   assign tx_valid_o = tx_valid_q;
   assign busy_o     = busy_q;

   function automatic logic [7:0] acc_byte(input logic [31:0] a, input logic [1:0] i);
      return a[8*i +: 8];
   endfunction

   function automatic logic rx_state(input state_t s);
      return (s == S_HDR0) || (s == S_HDR1) || (s == S_HDR2) || (s == S_HDR3) ||
             (s == S_PAYLOAD) || (s == S_DRAIN);
   endfunction

`ifdef ALU_DIV_EN
   // one restoring-division step: shift in next dividend bit, subtract if it fits
   always_comb begin
      r_sh  = {dr_q, dq_q[31]};
      r_ge  = (r_sh >= {1'b0, dv_q});
      dr_nx = r_ge ? 32'(r_sh - {1'b0, dv_q}) : r_sh[31:0];
      q_nx  = {dq_q[30:0], r_ge};
   end
`endif

   // accumulator value after folding the word completed by this byte
   always_comb begin
      acc_fold = acc_q;
      if (word_done) begin
         if (is_add)
            acc_fold = acc_q + word_nx;
         else if (is_mul)
            acc_fold = acc_q * word_nx;
`ifdef ALU_DIV_EN
         else if (is_div && first_q)
            acc_fold = word_nx;
`endif
      end
   end

   // packet sequencing: header parse, payload fold, divider, response send
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      len_lo_d   = len_lo_q;
      rem_d      = rem_q;
      bcnt_d     = bcnt_q;
      word_d     = word_q;
      acc_d      = acc_q;
      sidx_d     = sidx_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
`ifdef ALU_DIV_EN
      first_d    = first_q;
      dq_d       = dq_q;
      dr_d       = dr_q;
      dv_d       = dv_q;
      dcnt_d     = dcnt_q;
      dlast_d    = dlast_q;
`endif
      case (state_q)
         S_HDR0: if (rx_fire) begin
            op_d    = rx_data_i;
            acc_d   = (rx_data_i == OP_MUL) ? 32'd1 : '0;
            bcnt_d  = '0;
`ifdef ALU_DIV_EN
            first_d = 1'b1;
`endif
            state_d = S_HDR1;
         end
         S_HDR1: if (rx_fire) state_d = S_HDR2;
         S_HDR2: if (rx_fire) begin
            len_lo_d = rx_data_i;
            state_d  = S_HDR3;
         end
         S_HDR3: if (rx_fire) begin
            rem_d = LEN_W'(pay_len);
            if (pay_len == 16'd0) begin
               if (is_arith) begin
                  sidx_d     = '0;
                  tx_data_d  = acc_q[7:0];
                  tx_valid_d = 1'b1;
                  state_d    = S_SEND;
               end else begin
                  state_d = S_HDR0;
               end
            end else begin
               state_d = (is_echo || is_arith) ? S_PAYLOAD : S_DRAIN;
            end
         end
         S_PAYLOAD: if (rx_fire) begin
            rem_d  = rem_q - LEN_W'(1);
            bcnt_d = bcnt_q + 2'd1;
            word_d = word_nx;
            if (is_echo) begin
               tx_data_d  = rx_data_i;
               tx_valid_d = 1'b1;
               state_d    = S_ECHO_TX;
            end else begin
               acc_d = acc_fold;
`ifdef ALU_DIV_EN
               if (is_div && word_done)
                  first_d = 1'b0;
               if (is_div && word_done && !first_q) begin
                  dq_d    = acc_q;
                  dr_d    = '0;
                  dv_d    = word_nx;
                  dcnt_d  = '0;
                  dlast_d = last_byte;
                  state_d = S_DIV_RUN;
               end else
`endif
               if (last_byte) begin
                  sidx_d     = '0;
                  tx_data_d  = acc_fold[7:0];
                  tx_valid_d = 1'b1;
                  state_d    = S_SEND;
               end
            end
         end
         S_DRAIN: if (rx_fire) begin
            rem_d = rem_q - LEN_W'(1);
            if (last_byte) state_d = S_HDR0;
         end
         S_ECHO_TX: if (tx_fire) begin
            tx_valid_d = 1'b0;
            state_d    = (rem_q == '0) ? S_HDR0 : S_PAYLOAD;
         end
         S_SEND: if (tx_fire) begin
            if (sidx_q == 2'd3) begin
               tx_valid_d = 1'b0;
               state_d    = S_HDR0;
            end else begin
               sidx_d    = sidx_q + 2'd1;
               tx_data_d = acc_byte(acc_q, sidx_q + 2'd1);
            end
         end
`ifdef ALU_DIV_EN
         S_DIV_RUN: begin
            dq_d   = q_nx;
            dr_d   = dr_nx;
            dcnt_d = dcnt_q + 5'd1;
            if (dcnt_q == 5'd31) begin
               acc_d = q_nx;
               if (dlast_q) begin
                  sidx_d     = '0;
                  tx_data_d  = q_nx[7:0];
                  tx_valid_d = 1'b1;
                  state_d    = S_SEND;
               end else begin
                  state_d = S_PAYLOAD;
               end
            end
         end
`endif
         default: state_d = S_HDR0;
      endcase
   end

   // state and registered outputs; rx_ready/busy are decoded from next state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_HDR0;
         op_q       <= '0;
         len_lo_q   <= '0;
         rem_q      <= '0;
         bcnt_q     <= '0;
         word_q     <= '0;
         acc_q      <= '0;
         sidx_q     <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         rx_ready_q <= 1'b1;
         busy_q     <= 1'b0;
`ifdef ALU_DIV_EN
         first_q    <= 1'b0;
         dq_q       <= '0;
         dr_q       <= '0;
         dv_q       <= '0;
         dcnt_q     <= '0;
         dlast_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         len_lo_q   <= len_lo_d;
         rem_q      <= rem_d;
         bcnt_q     <= bcnt_d;
         word_q     <= word_d;
         acc_q      <= acc_d;
         sidx_q     <= sidx_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         rx_ready_q <= rx_state(state_d);
         busy_q     <= (state_d != S_HDR0);
`ifdef ALU_DIV_EN
         first_q    <= first_d;
         dq_q       <= dq_d;
         dr_q       <= dr_d;
         dv_q       <= dv_d;
         dcnt_q     <= dcnt_d;
         dlast_q    <= dlast_d;
`endif
      end
   end

endmodule
